// File: rtl/adc_capture_buf.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_buf
// Purpose  : Triggered snapshot buffer on the ADC AXI4-stream path. After an
//            arm + trigger sequence it stores a programmable-length, optionally
//            decimated burst of ADC words in internal block RAM. The local bus
//            reads the buffer back through a synchronous read port. The ADC
//            stream is never back-pressured.
// Revision : 1.0  initial release
// ============================================================================
module adc_capture_buf #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 10,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   dspclk,
  input  logic                   dspresetn,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   arm,
  input  logic                   trig,
  input  logic [ADDR_WIDTH:0]    len,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    wr_count,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int                  c_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [DECIM_WIDTH-1:0] decim_q, decim_d;
  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [ADDR_WIDTH:0]    wr_count_q, wr_count_d;
  logic [ADDR_WIDTH:0]    wr_count_inc;
  logic                   busy_q, done_q, tready_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  mem_q [c_DEPTH];

  assign wr_count_inc = wr_count_q + 1'b1;
  // Writes land at the current count; the length limit keeps this from wrapping.
  assign wr_addr      = wr_count_q[ADDR_WIDTH-1:0];

  // Next-state logic: arming, trigger qualification, decimation and length stop
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    decim_d    = decim_q;
    dcnt_d     = dcnt_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    if (abort) begin
      // Abort wins over everything, including a pending final write.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d    = S_ARMED;
            // Zero (or anything beyond the buffer) means a full-depth capture.
            len_d      = ((len == '0) || (len > c_FULL_LEN)) ? c_FULL_LEN : len;
            decim_d    = decim;
            dcnt_d     = '0;
            wr_count_d = '0;
          end
        end
        S_ARMED, S_CAPTURE: begin
          // The trigger cycle itself already captures (word 0 of the burst).
          if ((state_q == S_CAPTURE) || trig) begin
            state_d = S_CAPTURE;
            if (s_tvalid) begin
              if (dcnt_q == '0) begin
                wr_en      = 1'b1;
                wr_count_d = wr_count_inc;
                if (wr_count_inc == len_q) begin
                  state_d = S_DONE;
                end
              end
              dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, shadow and status registers with synchronous active-low reset
  always_ff @(posedge dspclk) begin
    if (!dspresetn) begin
      state_q    <= S_IDLE;
      len_q      <= c_FULL_LEN;
      decim_q    <= '0;
      dcnt_q     <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      decim_q    <= decim_d;
      dcnt_q     <= dcnt_d;
      wr_count_q <= wr_count_d;
      busy_q     <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_q     <= (state_d == S_DONE);
      tready_q   <= 1'b1;
    end
  end

  // Buffer write port; contents survive reset, but no write occurs while in reset
  always_ff @(posedge dspclk) begin
    if (dspresetn && wr_en) begin
      mem_q[wr_addr] <= s_tdata;
    end
  end

  // Read-first readback port, one cycle latency, independent of capture state
  always_ff @(posedge dspclk) begin
    if (!dspresetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign s_tready = tready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_buf
// Purpose  : Self-checking bench for adc_capture_buf. A behavioural model of
//            the buffer contents predicts every readback; expected readback
//            words are queued by the stimulus and consumed by a monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_buf;

  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int DCW   = 8;
  localparam int DEPTH = 1 << AW;

  localparam int V_ALL    = 0;
  localparam int V_TOGGLE = 1;
  localparam int V_RAND   = 2;

  logic           dspclk = 1'b0;
  logic           dspresetn = 1'b0;
  logic [DW-1:0]  s_tdata;
  logic           s_tvalid;
  logic           s_tready;
  logic           arm;
  logic           trig;
  logic [AW:0]    len;
  logic [DCW-1:0] decim;
  logic           abort;
  logic           busy;
  logic           done;
  logic [AW:0]    wr_count;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;

  always #5 dspclk = ~dspclk;

  adc_capture_buf #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DECIM_WIDTH(DCW)
  ) dut (
    .dspclk   (dspclk),
    .dspresetn(dspresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .arm      (arm),
    .trig     (trig),
    .len      (len),
    .decim    (decim),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of the buffer: contents plus which words are known.
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic          rd_req = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: a read issued in a cycle is checked just after the following edge.
  always @(posedge dspclk) begin
    logic req;
    req = rd_req;
    #1;
    if (req) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_scoreboard_empty: got %0h expected none", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue_read(input int a);
    rd_addr = AW'(a);
    rd_req  = 1'b1;
    exp_q.push_back(ref_mem[a]);
  endtask

  // One arm/trigger/capture sequence. stop_at >= 0 interrupts the capture just
  // before write number stop_at, by abort (stop_rst=0) or by reset (stop_rst=1).
  task automatic run_capture(input int ln, input int dc, input int tdelay, input int vmode,
                             input bit counting, input logic [DW-1:0] base,
                             input int stop_at, input bit stop_rst, input bit noise);
    int            L;
    int            written;
    int            vidx;
    int            cyc;
    bit            first;
    bit            fin;
    bit            stopped;
    bit            v;
    bit            wcyc;
    logic [DW-1:0] d;
    L       = (ln == 0) ? DEPTH : ln;
    written = 0;
    vidx    = 0;
    cyc     = 0;
    first   = 1'b1;
    fin     = 1'b0;
    stopped = 1'b0;

    arm      = 1'b1;
    len      = ln[AW:0];
    decim    = dc[DCW-1:0];
    trig     = 1'b0;
    s_tvalid = 1'($urandom % 2);
    s_tdata  = rnd();
    @(negedge dspclk);
    // Shadowed settings: scrambling them after arm must not matter.
    arm   = 1'b0;
    len   = (AW+1)'($urandom);
    decim = DCW'($urandom);
    chk("armed_busy", DW'(busy), DW'(1));
    chk("armed_done", DW'(done), DW'(0));
    chk("arm_clears_wr_count", DW'(wr_count), DW'(0));

    for (int i = 0; i < tdelay; i++) begin
      s_tvalid = 1'($urandom % 2);
      s_tdata  = rnd();
      arm      = noise && ($urandom % 4 == 0);
      @(negedge dspclk);
      chk("armed_wait_busy", DW'(busy), DW'(1));
      chk("armed_wait_wr_count", DW'(wr_count), DW'(0));
    end

    while (!fin) begin
      if (cyc > 20000) begin
        tests++;
        fails++;
        $display("FAIL capture_timeout: got %0d writes expected %0d", written, L);
        break;
      end
      trig = first ? 1'b1 : 1'($urandom % 2);
      first = 1'b0;
      case (vmode)
        V_ALL:    v = 1'b1;
        V_TOGGLE: v = (cyc % 2 == 0);
        default:  v = ($urandom % 3 != 0);
      endcase
      d        = counting ? base + DW'(vidx) : rnd();
      s_tvalid = v;
      s_tdata  = d;
      arm      = noise && ($urandom % 5 == 0);
      wcyc     = v && (vidx % (dc + 1) == 0);
      if ((stop_at >= 0) && (written == stop_at) && wcyc) begin
        stopped = 1'b1;
        fin     = 1'b1;
        if (stop_rst) begin
          dspresetn = 1'b0;
          rd_req    = 1'b0;
        end else begin
          abort = 1'b1;
          if (ref_known[written]) issue_read(written); else rd_req = 1'b0;
        end
      end else begin
        // Probe the address about to be written: old contents must come back.
        if (ref_known[written]) issue_read(written); else rd_req = 1'b0;
        if (v) begin
          if (wcyc) begin
            ref_mem[written]   = d;
            ref_known[written] = 1'b1;
            written++;
          end
          vidx++;
        end
        if (written == L) fin = 1'b1;
      end
      cyc++;
      @(negedge dspclk);
    end

    abort    = 1'b0;
    arm      = 1'b0;
    trig     = 1'b0;
    rd_req   = 1'b0;
    s_tvalid = 1'b0;
    if (stopped && stop_rst) begin
      chk("rst_tready", DW'(s_tready), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_wr_count", DW'(wr_count), DW'(0));
      dspresetn = 1'b1;
      @(negedge dspclk);
      chk("rst_release_tready", DW'(s_tready), DW'(1));
    end else if (stopped) begin
      chk("abort_busy", DW'(busy), DW'(0));
      chk("abort_done", DW'(done), DW'(0));
      chk("abort_wr_count", DW'(wr_count), DW'(written));
    end else begin
      chk("end_done", DW'(done), DW'(1));
      chk("end_busy", DW'(busy), DW'(0));
      chk("end_wr_count", DW'(wr_count), DW'(L));
      chk("end_tready", DW'(s_tready), DW'(1));
    end

    // Further traffic and triggers after the capture must change nothing.
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = rnd();
      trig     = 1'b1;
      @(negedge dspclk);
    end
    s_tvalid = 1'b0;
    trig     = 1'b0;
    if (!stopped) begin
      chk("hold_done", DW'(done), DW'(1));
      chk("hold_wr_count", DW'(wr_count), DW'(L));
    end else if (!stop_rst) begin
      chk("hold_idle_wr_count", DW'(wr_count), DW'(written));
      chk("hold_idle_busy", DW'(busy), DW'(0));
    end

    // Read back every captured word plus the first word past the capture.
    for (int a = 0; a <= written && a < DEPTH; a++) begin
      if (ref_known[a]) begin
        issue_read(a);
        @(negedge dspclk);
      end
    end
    rd_req = 1'b0;
    @(negedge dspclk);
  endtask

  initial begin
    s_tdata  = '0;
    s_tvalid = 1'b0;
    arm      = 1'b0;
    trig     = 1'b0;
    abort    = 1'b0;
    len      = '0;
    decim    = '0;
    rd_addr  = '0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

    dspresetn = 1'b0;
    repeat (3) @(negedge dspclk);
    chk("reset_tready", DW'(s_tready), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_done", DW'(done), DW'(0));
    chk("reset_wr_count", DW'(wr_count), DW'(0));
    chk("reset_rd_data", rd_data, DW'(0));
    dspresetn = 1'b1;
    @(negedge dspclk);
    chk("release_tready", DW'(s_tready), DW'(1));
    chk("release_busy", DW'(busy), DW'(0));

    // Basic burst 0x10..0x13
    run_capture(4, 0, 0, V_ALL, 1'b1, DW'('h10), -1, 1'b0, 1'b0);
    // Decimate by 3: words 0,3,6
    run_capture(3, 2, 0, V_ALL, 1'b1, DW'(0), -1, 1'b0, 1'b0);
    // Long armed wait, first stored word 0x55
    run_capture(4, 0, 20, V_ALL, 1'b1, DW'('h55), -1, 1'b0, 1'b0);
    // Full depth with toggling valid
    run_capture(0, 0, 3, V_TOGGLE, 1'b0, DW'(0), -1, 1'b0, 1'b0);
    // Abort coincident with the sixth write
    run_capture(8, 0, 2, V_ALL, 1'b1, DW'('h100), 5, 1'b0, 1'b0);
    // Re-arm after abort, decimated and noisy
    run_capture(6, 1, 1, V_RAND, 1'b0, DW'(0), -1, 1'b0, 1'b1);
    // Randomised captures
    for (int k = 0; k < 6; k++) begin
      run_capture(int'($urandom_range(1, 48)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), V_RAND, 1'b0, DW'(0), -1, 1'b0, 1'b1);
    end
    // Abort with decimation mid-burst
    run_capture(20, 2, 0, V_RAND, 1'b0, DW'(0), 7, 1'b0, 1'b1);
    // Reset during capture, then a clean capture afterwards
    run_capture(8, 0, 0, V_ALL, 1'b1, DW'('hA0), 3, 1'b1, 1'b0);
    run_capture(5, 0, 0, V_RAND, 1'b0, DW'(0), -1, 1'b0, 1'b1);

    repeat (3) @(negedge dspclk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rd_scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
